// File: rtl/iic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iic_pkg : shared types and constants for the I2C responder       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package iic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DEV    = 3'd1,
      RH     = 3'd2,
      RL     = 3'd3,
      WR     = 3'd4,
      RD     = 3'd5,
      IGNORE = 3'd6
   } state_t;

   localparam int   c_BYTE_W = 8;
   localparam int   c_ADDR_W = 16;
   localparam logic c_ACK    = 1'b0;
   localparam logic c_NACK   = 1'b1;

   function automatic logic [c_ADDR_W-1:0] ptr_inc(input logic [c_ADDR_W-1:0] p);
      return p + c_ADDR_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/iic_slave_resp_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iic_slave_resp_if : bus lines and register-file port bundle      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface iic_slave_resp_if;
   import iic_pkg::*;

   logic                scl_i;
   logic                sda_i;
   logic                sda_t;
   logic                wr_en;
   logic [c_ADDR_W-1:0] wr_addr;
   logic [c_BYTE_W-1:0] wr_data;
   logic                rd_req;
   logic [c_ADDR_W-1:0] rd_addr;
   logic [c_BYTE_W-1:0] rd_data;
   logic                busy;
   logic                stop_det;

   modport slave (
      input  scl_i, sda_i, rd_data,
      output sda_t, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy, stop_det
   );

   modport master (
      output scl_i, sda_i, rd_data,
      input  sda_t, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy, stop_det
   );

endinterface
`default_nettype wire

// File: rtl/iic_line_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iic_line_sync : multi-stage synchronizer with edge detection     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module iic_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Preset high so an idle (pulled-up) bus produces no edge out of reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/iic_slave_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iic_slave_resp : I2C target with 16-bit register pointer         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module iic_slave_resp
   import iic_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h3C,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_n,
   iic_slave_resp_if.slave   bus
);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;

   iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk_i(clk_i), .rst_n(rst_n), .i_d(bus.scl_i),
      .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
   );

   iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk_i(clk_i), .rst_n(rst_n), .i_d(bus.sda_i),
      .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
   );

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_bitcnt, w_bitcnt_nxt;
   logic [6:0]          r_shift, w_shift_nxt;
   logic [c_ADDR_W-1:0] r_ptr, w_ptr_nxt;
   logic [c_BYTE_W-1:0] r_tx, w_tx_nxt;
   logic                r_ack_ok, w_ack_ok_nxt;
   logic                r_rd_pend, w_rd_pend_nxt;
   logic                r_sda_t, w_sda_t_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_stop_det, w_stop_det_nxt;
   logic                r_wr_en, w_wr_en_nxt;
   logic [c_ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [c_BYTE_W-1:0] r_wr_data, w_wr_data_nxt;
   logic                r_rd_req, w_rd_req_nxt;
   logic [c_ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;

   logic                w_start, w_stop, w_active;
   logic [c_BYTE_W-1:0] w_byte;

   assign w_start  = w_scl & w_sda_fall;
   assign w_stop   = w_scl & w_sda_rise;
   assign w_active = (r_state != IDLE) && (r_state != IGNORE);
   assign w_byte   = {r_shift, w_sda};

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_tx       <= '0;
         r_ack_ok   <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_sda_t    <= 1'b1;
         r_busy     <= 1'b0;
         r_stop_det <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rd_req   <= 1'b0;
         r_rd_addr  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bitcnt   <= w_bitcnt_nxt;
         r_shift    <= w_shift_nxt;
         r_ptr      <= w_ptr_nxt;
         r_tx       <= w_tx_nxt;
         r_ack_ok   <= w_ack_ok_nxt;
         r_rd_pend  <= w_rd_pend_nxt;
         r_sda_t    <= w_sda_t_nxt;
         r_busy     <= w_busy_nxt;
         r_stop_det <= w_stop_det_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_rd_req   <= w_rd_req_nxt;
         r_rd_addr  <= w_rd_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bitcnt_nxt   = r_bitcnt;
      w_shift_nxt    = r_shift;
      w_ptr_nxt      = r_ptr;
      w_tx_nxt       = r_rd_pend ? bus.rd_data : r_tx;
      w_ack_ok_nxt   = r_ack_ok;
      w_rd_pend_nxt  = r_rd_req;
      w_sda_t_nxt    = r_sda_t;
      w_busy_nxt     = r_busy;
      w_stop_det_nxt = 1'b0;
      w_wr_en_nxt    = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      w_rd_req_nxt   = 1'b0;
      w_rd_addr_nxt  = r_rd_addr;

      if (w_stop) begin
         w_state_nxt    = IDLE;
         w_sda_t_nxt    = c_NACK;
         w_busy_nxt     = 1'b0;
         w_stop_det_nxt = 1'b1;
         w_ack_ok_nxt   = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = DEV;
         w_bitcnt_nxt = '0;
         w_sda_t_nxt  = c_NACK;
         w_busy_nxt   = 1'b0;
         w_ack_ok_nxt = 1'b0;
      end else if (w_active && w_scl_rise) begin
         if (r_bitcnt < 4'd8) begin
            w_shift_nxt  = w_byte[6:0];
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            // Byte decisions are taken on the 8th rise; the ACK follows on the next fall.
            if (r_bitcnt == 4'd7) begin
               case (r_state)
                  DEV: begin
                     if (w_byte[7:1] == DEV_ADDR) begin
                        w_busy_nxt   = 1'b1;
                        w_ack_ok_nxt = 1'b1;
                        if (w_byte[0]) begin
                           w_state_nxt   = RD;
                           w_rd_req_nxt  = 1'b1;
                           w_rd_addr_nxt = r_ptr;
                        end else begin
                           w_state_nxt = RH;
                        end
                     end else begin
                        w_state_nxt = IGNORE;
                     end
                  end
                  RH: begin
                     w_ptr_nxt[15:8] = w_byte;
                     w_ack_ok_nxt    = 1'b1;
                     w_state_nxt     = RL;
                  end
                  RL: begin
                     w_ptr_nxt[7:0] = w_byte;
                     w_ack_ok_nxt   = 1'b1;
                     w_state_nxt    = WR;
                  end
                  WR: begin
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = r_ptr;
                     w_wr_data_nxt = w_byte;
                     w_ptr_nxt     = ptr_inc(r_ptr);
                     w_ack_ok_nxt  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end else if (r_bitcnt == 4'd8) begin
            w_bitcnt_nxt = 4'd9;
            // In RD the 9th clock belongs to the master unless it is our device-byte ACK.
            if (r_state == RD && !r_ack_ok) begin
               if (w_sda == c_ACK) begin
                  w_ptr_nxt     = ptr_inc(r_ptr);
                  w_rd_req_nxt  = 1'b1;
                  w_rd_addr_nxt = ptr_inc(r_ptr);
               end else begin
                  w_state_nxt = IGNORE;
               end
            end
         end
      end else if (w_active && w_scl_fall) begin
         if (r_bitcnt == 4'd8) begin
            w_sda_t_nxt = r_ack_ok ? c_ACK : c_NACK;
         end else if (r_bitcnt == 4'd9) begin
            w_bitcnt_nxt = '0;
            w_ack_ok_nxt = 1'b0;
            w_sda_t_nxt  = (r_state == RD) ? r_tx[7] : c_NACK;
         end else if (r_state == RD && r_bitcnt != 4'd0) begin
            w_sda_t_nxt = r_tx[3'd7 - r_bitcnt[2:0]];
         end
      end
   end

   assign bus.sda_t    = r_sda_t;
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.rd_req   = r_rd_req;
   assign bus.rd_addr  = r_rd_addr;
   assign bus.busy     = r_busy;
   assign bus.stop_det = r_stop_det;

endmodule
`default_nettype wire

// File: tb/tb_iic_slave_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_iic_slave_resp : directed + randomized bench for the responder|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_iic_slave_resp;
   import iic_pkg::*;

   localparam int Q = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   iic_slave_resp_if bus ();

   assign bus.scl_i = scl_m;
   assign bus.sda_i = sda_m & bus.sda_t;

   iic_slave_resp #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
      .clk_i(clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial forever #5 clk = ~clk;

   // Register file model: preload port for the bench, write port for the DUT.
   logic [7:0]  regfile [0:65535];
   logic        pre_en   = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   always @(posedge clk) begin
      if (pre_en)      regfile[pre_addr]    <= pre_data;
      if (bus.wr_en)   regfile[bus.wr_addr] <= bus.wr_data;
      if (bus.rd_req)  bus.rd_data          <= regfile[bus.rd_addr];
   end

   logic [23:0] wr_q [$];
   logic [15:0] rd_q [$];
   int stop_cnt = 0;
   int both_cnt = 0;

   always @(negedge clk) begin
      if (bus.wr_en)                wr_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.rd_req)               rd_q.push_back(bus.rd_addr);
      if (bus.stop_det)             stop_cnt++;
      if (bus.wr_en && bus.rd_req)  both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
      wq();
   endtask

   task automatic send_bit(input logic b, output logic obs);
      sda_m = b;    wq();
      scl_m = 1'b1; wq();
      obs = bus.sda_i;
      wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) send_bit(b[i], d);
      send_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] data);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, x);
         data[i] = x;
      end
      send_bit(mack, x);
   endtask

   initial begin
      logic        ack;
      logic [7:0]  rb;
      logic [7:0]  rh;
      logic [15:0] ptr;
      logic [7:0]  dat [4];
      int          n, s0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sda_t",   32'(bus.sda_t),    32'd1);
      chk("rst_wr_en",   32'(bus.wr_en),    32'd0);
      chk("rst_rd_req",  32'(bus.rd_req),   32'd0);
      chk("rst_busy",    32'(bus.busy),     32'd0);
      chk("rst_stop",    32'(bus.stop_det), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr),  32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr),  32'd0);
      rst_n = 1'b1;
      wq();
      chk("rst_state", 32'(dut.r_state), 32'(IDLE));

      // Single write
      wr_q.delete(); s0 = stop_cnt;
      i2c_start();
      write_byte(8'h78, ack); chk("w1_ack_dev", 32'(ack), 32'd0);
      chk("w1_busy", 32'(bus.busy), 32'd1);
      write_byte(8'h12, ack); chk("w1_ack_rh", 32'(ack), 32'd0);
      write_byte(8'h34, ack); chk("w1_ack_rl", 32'(ack), 32'd0);
      write_byte(8'hA5, ack); chk("w1_ack_d",  32'(ack), 32'd0);
      i2c_stop();
      chk("w1_wr_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("w1_wr_entry", 32'(wr_q[0]), 32'h1234A5);
      chk("w1_stop_cnt", 32'(stop_cnt - s0), 32'd1);
      chk("w1_busy_after", 32'(bus.busy), 32'd0);

      // Address mismatch
      wr_q.delete(); rd_q.delete();
      i2c_start();
      write_byte(8'h7A, ack); chk("mm_nack", 32'(ack), 32'd1);
      chk("mm_busy", 32'(bus.busy), 32'd0);
      write_byte(8'h55, ack); chk("mm_nack2", 32'(ack), 32'd1);
      chk("mm_state", 32'(dut.r_state), 32'(IGNORE));
      i2c_stop();
      chk("mm_wr_count", 32'(wr_q.size()), 32'd0);
      chk("mm_rd_count", 32'(rd_q.size()), 32'd0);

      // Burst write across the pointer wrap
      wr_q.delete();
      i2c_start();
      write_byte(8'h78, ack);
      write_byte(8'hFF, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack); chk("bw_ack1", 32'(ack), 32'd0);
      write_byte(8'h22, ack); chk("bw_ack2", 32'(ack), 32'd0);
      i2c_stop();
      chk("bw_wr_count", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() > 1) begin
         chk("bw_wr0", 32'(wr_q[0]), 32'hFFFF11);
         chk("bw_wr1", 32'(wr_q[1]), 32'h000022);
      end

      // Random read with repeated START
      pre_en = 1'b1; pre_addr = 16'h0010; pre_data = 8'h5A;
      @(posedge clk); #1;
      pre_addr = 16'h0011; pre_data = 8'hC3;
      @(posedge clk); #1;
      pre_en = 1'b0;
      rd_q.delete();
      i2c_start();
      write_byte(8'h78, ack);
      write_byte(8'h00, ack);
      write_byte(8'h10, ack);
      i2c_start();
      write_byte(8'h79, ack); chk("rr_ack_dev", 32'(ack), 32'd0);
      read_byte(1'b0, rb);    chk("rr_byte0",   32'(rb),  32'h5A);
      read_byte(1'b1, rb);    chk("rr_byte1",   32'(rb),  32'hC3);
      chk("rr_state", 32'(dut.r_state), 32'(IGNORE));
      chk("rr_sda_t", 32'(bus.sda_t), 32'd1);
      chk("rr_rd_count", 32'(rd_q.size()), 32'd2);
      if (rd_q.size() > 1) begin
         chk("rr_addr0", 32'(rd_q[0]), 32'h0010);
         chk("rr_addr1", 32'(rd_q[1]), 32'h0011);
      end
      i2c_stop();
      chk("rr_state_stop", 32'(dut.r_state), 32'(IDLE));

      // STOP after a partial data byte
      wr_q.delete();
      i2c_start();
      write_byte(8'h78, ack);
      write_byte(8'h00, ack);
      write_byte(8'h20, ack);
      for (int i = 0; i < 4; i++) send_bit(1'b1, ack);
      i2c_stop();
      chk("ps_wr_count", 32'(wr_q.size()), 32'd0);
      chk("ps_state", 32'(dut.r_state), 32'(IDLE));
      chk("ps_sda_t", 32'(bus.sda_t), 32'd1);

      // Reset while driving the RH ACK
      i2c_start();
      write_byte(8'h78, ack);
      rh = 8'hAB;
      for (int i = 7; i >= 0; i--) send_bit(rh[i], ack);
      chk("rs_ack_drive", 32'(bus.sda_t), 32'd0);
      sda_m = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rs_sda_t", 32'(bus.sda_t), 32'd1);
      chk("rs_busy",  32'(bus.busy),  32'd0);
      scl_m = 1'b1; wq();
      scl_m = 1'b0; wq();
      i2c_stop();
      wr_q.delete();
      i2c_start();
      write_byte(8'h78, ack); chk("rs_w_ack", 32'(ack), 32'd0);
      write_byte(8'hAB, ack);
      write_byte(8'hCD, ack);
      write_byte(8'h5E, ack);
      i2c_stop();
      chk("rs_wr_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("rs_wr_entry", 32'(wr_q[0]), 32'hABCD5E);

      // Randomized write bursts read back through the pointer
      for (int it = 0; it < 4; it++) begin
         ptr = (it == 0) ? 16'hFFFE : 16'($urandom);
         n   = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
         wr_q.delete(); rd_q.delete();
         i2c_start();
         write_byte(8'h78, ack);
         write_byte(ptr[15:8], ack);
         write_byte(ptr[7:0], ack);
         for (int i = 0; i < n; i++) begin
            write_byte(dat[i], ack);
            chk($sformatf("rnd%0d_wack%0d", it, i), 32'(ack), 32'd0);
         end
         i2c_stop();
         chk($sformatf("rnd%0d_wr_count", it), 32'(wr_q.size()), 32'(n));
         for (int i = 0; i < n && i < wr_q.size(); i++)
            chk($sformatf("rnd%0d_wr%0d", it, i), 32'(wr_q[i]),
                32'({16'((32'(ptr) + i) % 65536), dat[i]}));
         i2c_start();
         write_byte(8'h78, ack);
         write_byte(ptr[15:8], ack);
         write_byte(ptr[7:0], ack);
         i2c_start();
         write_byte(8'h79, ack);
         for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1), rb);
            chk($sformatf("rnd%0d_rd%0d", it, i), 32'(rb), 32'(dat[i]));
         end
         i2c_stop();
         chk($sformatf("rnd%0d_rd_count", it), 32'(rd_q.size()), 32'(n));
         for (int i = 0; i < n && i < rd_q.size(); i++)
            chk($sformatf("rnd%0d_rdaddr%0d", it, i), 32'(rd_q[i]),
                32'((32'(ptr) + i) % 65536));
      end

      chk("no_wr_rd_overlap", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
